// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD counter with tick prescaler, debounced start/stop and clear keys, and a STOP/RUN controller.
// Optional build macro COUNTER_DOWN_EN adds a dir input (1 = count down).
module bcd_counter_2digit #(
  parameter int unsigned CLK_HZ       = 12_000_000,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned DEBOUNCE_CYC = 240_000,
  parameter int unsigned MAX_COUNT    = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_clr,
`ifdef COUNTER_DOWN_EN
  input  logic       dir,
`endif
  output logic [3:0] data1,
  output logic [3:0] data2,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned PERIOD   = CLK_HZ / TICK_HZ;
  localparam int unsigned PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [3:0]  MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0]  MAX_ONES = 4'(MAX_COUNT % 10);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      key_raw, sync1, sync2, level, level_q, press;
  logic [CW-1:0]   db_cnt [2];
  logic [PW-1:0]   presc;
  logic            start_press, clr_press, tick, down;

  // Bit 0 = start key, bit 1 = clear key; both active-low.
  assign key_raw = {key_clr, key_start};

  // A key level is accepted only after the synchronised input differs from it
  // for DEBOUNCE_CYC consecutive cycles; any return to the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '1;
      sync2   <= '1;
      level   <= '1;
      level_q <= '1;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= key_raw;
      sync2   <= sync1;
      level_q <= level;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press       = level_q & ~level;
  assign start_press = press[0];
  assign clr_press   = press[1];

`ifdef COUNTER_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  assign tick    = (state_q == RUN) && (presc == PW'(PERIOD - 1));
  assign running = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STOP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_press)        state_d = STOP;
    else if (start_press) state_d = (state_q == RUN) ? STOP : RUN;
  end

  // Prescaler only advances while staying in RUN, so the first tick lands one full period after entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           presc <= '0;
    else if (clr_press || state_q != RUN || state_d != RUN) presc <= '0;
    else if (tick)                                         presc <= '0;
    else                                                   presc <= presc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1 <= '0;
      data2 <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_press) begin
        data1 <= '0;
        data2 <= '0;
      end else if (tick) begin
        if (down) begin
          if (data1 == 4'd0 && data2 == 4'd0) begin
            data1 <= MAX_TENS;
            data2 <= MAX_ONES;
            wrap  <= 1'b1;
          end else if (data2 == 4'd0) begin
            data2 <= 4'd9;
            data1 <= data1 - 1'b1;
          end else begin
            data2 <= data2 - 1'b1;
          end
        end else begin
          if (data1 == MAX_TENS && data2 == MAX_ONES) begin
            data1 <= '0;
            data2 <= '0;
            wrap  <= 1'b1;
          end else if (data2 == 4'd9) begin
            data2 <= '0;
            data1 <= data1 + 1'b1;
          end else begin
            data2 <= data2 + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Bench for bcd_counter_2digit: randomized key timing checked against an integer-count reference model.
// Define COUNTER_DOWN_EN to also exercise the dir input.
module tb_bcd_counter_2digit;
  localparam int CLK_HZ = 10;
  localparam int TICK_HZ = 1;
  localparam int DB = 4;
  localparam int MAXC = 12;
  localparam int PERIOD = CLK_HZ / TICK_HZ;
  localparam int LAT = 2 + DB + 1;

  logic       clk = 1'b0;
  logic       rst_n, key_start, key_clr;
  logic [3:0] data1, data2;
  logic       running, wrap;
`ifdef COUNTER_DOWN_EN
  logic       dir;
`endif

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int start_at = -1;
  int clr_at = -1;
  int m_count = 0;
  int m_phase = 0;
  bit m_run = 1'b0;
  bit m_wrap = 1'b0;
  bit m_dir = 1'b0;

  always #5 clk = ~clk;

  bcd_counter_2digit #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DEBOUNCE_CYC(DB),
    .MAX_COUNT(MAXC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_start(key_start),
    .key_clr(key_clr),
`ifdef COUNTER_DOWN_EN
    .dir(dir),
`endif
    .data1(data1),
    .data2(data2),
    .running(running),
    .wrap(wrap)
  );

  function automatic logic [9:0] exp_vec();
    return {4'(m_count / 10), 4'(m_count % 10), m_run, m_wrap};
  endfunction

  // Advance one clock and update the reference model; sample point is 1 ns after the edge.
  task automatic cyc();
    bit t;
    @(posedge clk);
    cyc_n++;
`ifdef COUNTER_DOWN_EN
    m_dir = dir;
`endif
    t = m_run && (m_phase == PERIOD - 1);
    m_wrap = 1'b0;
    if (cyc_n == clr_at) begin
      m_run = 1'b0;
      m_count = 0;
      m_phase = 0;
    end else begin
      if (t) begin
        if (m_dir) begin
          if (m_count == 0) begin m_count = MAXC; m_wrap = 1'b1; end
          else m_count = m_count - 1;
        end else begin
          if (m_count == MAXC) begin m_count = 0; m_wrap = 1'b1; end
          else m_count = m_count + 1;
        end
      end
      if (m_run) m_phase = t ? 0 : m_phase + 1;
      if (cyc_n == start_at) begin
        m_run = !m_run;
        m_phase = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_start = 1'b1;
    key_clr = 1'b1;
`ifdef COUNTER_DOWN_EN
    dir = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({data1, data2, running, wrap} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=000", {data1, data2, running, wrap});
    end
    for (int i = 0; i < 50; i++) begin
      cyc();
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL idle cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
    end
  endtask

  task automatic test_start();
    key_start = 1'b0;
    start_at = cyc_n + LAT;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (i == 9) key_start = 1'b1;
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL start cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
      if (i == LAT - 2 || i == LAT - 1) begin
        checks++;
        if (running !== (i == LAT - 1)) begin
          failures++;
          $display("FAIL start_latency edge=%0d running=%b exp=%b", i + 1, running, (i == LAT - 1));
        end
      end
      if (i == LAT - 1 + PERIOD || i == LAT - 1 + 2 * PERIOD) begin
        checks++;
        if (data2 !== 4'((i - LAT + 1) / PERIOD)) begin
          failures++;
          $display("FAIL first_ticks edge=%0d data2=%0d exp=%0d", i + 1, data2, (i - LAT + 1) / PERIOD);
        end
      end
    end
  endtask

  task automatic test_count_wrap();
    int n, wraps;
    n = 14 * PERIOD + int'($urandom_range(0, 13 * PERIOD));
    wraps = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (wrap === 1'b1) wraps++;
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL count_wrap cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
    end
    checks++;
    if (wraps < 1) begin
      failures++;
      $display("FAIL wrap_seen got=%0d exp>=1", wraps);
    end
  endtask

  task automatic test_bounce();
    int len;
    // Regular bounce: 2 low / 2 high for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      key_start = ((i / 2) % 2 == 1);
      cyc();
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL bounce_fixed cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
    end
    // Random short glitches on both keys, each shorter than the debounce window.
    for (int k = 0; k < 8; k++) begin
      len = int'($urandom_range(1, DB - 1));
      key_start = (k % 2 == 1);
      key_clr = (k % 2 == 1) || ($urandom_range(0, 1) == 1);
      for (int j = 0; j < len; j++) begin
        cyc();
        checks++;
        if ({data1, data2, running, wrap} !== exp_vec()) begin
          failures++;
          $display("FAIL bounce_rand cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
        end
      end
    end
    key_start = 1'b1;
    key_clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL bounce_settle cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
    end
    // Genuine press while running -> STOP with the count frozen.
    len = int'($urandom_range(LAT, 15));
    key_start = 1'b0;
    start_at = cyc_n + LAT;
    for (int i = 0; i < len + 3 * PERIOD; i++) begin
      cyc();
      if (i == len - 1) key_start = 1'b1;
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL stop_press cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
    end
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL stopped running=%b exp=0", running);
    end
  endtask

  task automatic test_clear_tick();
    bit found;
    found = 1'b0;
    key_start = 1'b0;
    start_at = cyc_n + LAT;
    for (int i = 0; i < 1500 && !found; i++) begin
      cyc();
      if (i == 10) key_start = 1'b1;
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL clear_setup cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
      if (i > 10 && m_run && m_count == 5 && m_phase == PERIOD - LAT) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL clear_setup_timeout got=notfound exp=count05");
    end
    key_clr = 1'b0;
    clr_at = cyc_n + LAT;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 9) key_clr = 1'b1;
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL clear_tick cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
      if (cyc_n == clr_at) begin
        checks++;
        if ({data1, data2, running, wrap} !== 10'd0) begin
          failures++;
          $display("FAIL clear_wins got=%h exp=000", {data1, data2, running, wrap});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = LAT + int'($urandom_range(15, 60));
    key_start = 1'b0;
    start_at = cyc_n + LAT;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (i == 10) key_start = 1'b1;
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data1, data2, running, wrap} !== 10'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=000", {data1, data2, running, wrap});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_count = 0;
    m_run = 1'b0;
    m_phase = 0;
    m_wrap = 1'b0;
    start_at = -1;
    clr_at = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
    end
  endtask

`ifdef COUNTER_DOWN_EN
  task automatic test_down();
    bit found;
    found = 1'b0;
    key_start = 1'b0;
    start_at = cyc_n + LAT;
    for (int i = 0; i < 500 && !found; i++) begin
      cyc();
      if (i == 10) key_start = 1'b1;
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL down_setup cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
      if (i > 10 && m_run && m_count == 1 && m_phase == 0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL down_setup_timeout got=notfound exp=count01");
    end
    dir = 1'b1;
    for (int i = 1; i <= 3 * PERIOD; i++) begin
      cyc();
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL down cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
      if (i == PERIOD || i == 2 * PERIOD || i == 3 * PERIOD) begin
        checks++;
        if ({data1, data2, wrap} !== ((i == PERIOD) ? 9'h000 : (i == 2 * PERIOD) ? 9'h025 : 9'h022)) begin
          failures++;
          $display("FAIL down_seq step=%0d got=%h", i / PERIOD, {data1, data2, wrap});
        end
      end
    end
    dir = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      cyc();
      checks++;
      if ({data1, data2, running, wrap} !== exp_vec()) begin
        failures++;
        $display("FAIL up_again cyc=%0d got=%h exp=%h", cyc_n, {data1, data2, running, wrap}, exp_vec());
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_start();
    test_count_wrap();
    test_bounce();
    test_clear_tick();
    test_reset_mid();
`ifdef COUNTER_DOWN_EN
    test_down();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
